// File: rtl/tim_ctrl_if.sv
// Bus interface for the tim_ctrl register window.
//   bus_sel    access strobe, one cycle per access
//   bus_we     1=write, 0=read
//   bus_addr   byte address (bits [1:0] ignored)
//   bus_wdata  write data
//   bus_rdata  read data, valid the cycle after bus_sel
//   bus_ready  registered echo of bus_sel
interface tim_ctrl_if #(
   parameter int ADDR_W = 5
) ();
   logic              bus_sel;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [31:0]       bus_wdata;
   logic [31:0]       bus_rdata;
   logic              bus_ready;

   modport master (output bus_sel, bus_we, bus_addr, bus_wdata,
                   input  bus_rdata, bus_ready);
   modport slave  (input  bus_sel, bus_we, bus_addr, bus_wdata,
                   output bus_rdata, bus_ready);
endinterface

// File: rtl/tim_ctrl.sv
// Control/scheduler for one general-purpose timer.
// Holds preload registers (PSC, ARR, CCR1, CCR2) and mode bits, moves them
// into the active values driving the timer, edge-detects the timer event
// into UIF/irq, and implements one-pulse mode and a UG forced restart.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   bus             register bus (slave side)
//   tim_en          timer enable
//   tim_countdown   count direction (1=down)
//   tim_psc/arr/ccr1/ccr2  active timer values
//   tim_cnt         current counter value (read via CNT)
//   tim_event       timer event level
//   irq             interrupt request (UIF & UIE)
module tim_ctrl #(
   parameter int          ADDR_W  = 5,
   parameter logic [15:0] PSC_RST = 16'd2,
   parameter logic [15:0] ARR_RST = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   tim_ctrl_if.slave        bus,
   output logic             tim_en,
   output logic             tim_countdown,
   output logic [15:0]      tim_psc,
   output logic [15:0]      tim_arr,
   output logic [15:0]      tim_ccr1,
   output logic [15:0]      tim_ccr2,
   input  logic [15:0]      tim_cnt,
   input  logic             tim_event,
   output logic             irq
);

   typedef enum logic [1:0] {IDLE, RUN, RESTART} state_e;

   // CR bit positions
   localparam int EN = 0, DIR = 1, ARPE = 2, OPM = 3, UIE = 4;

   state_e      state_q, state_d;
   logic [4:0]  cr_q, cr_d;
   logic        uif_q, uif_d;
   logic [15:0] psc_q, psc_d, arr_q, arr_d, ccr1_q, ccr1_d, ccr2_q, ccr2_d;
   logic [15:0] psc_a_q, psc_a_d, arr_a_q, arr_a_d;
   logic [15:0] ccr1_a_q, ccr1_a_d, ccr2_a_q, ccr2_a_d;
   logic        tim_en_q, tim_en_d;
   logic        ev_q;
   logic        irq_q, irq_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q;

   logic              wr, rd, upd, ug, load_all, imm;
   logic [ADDR_W-3:0] widx;
   logic [15:0]       wd;
   logic              unused_ok;

   assign wr   = bus.bus_sel & bus.bus_we;
   assign rd   = bus.bus_sel & ~bus.bus_we;
   assign widx = bus.bus_addr[ADDR_W-1:2];
   assign wd   = bus.bus_wdata[15:0];
   assign upd  = tim_event & ~ev_q;
   assign unused_ok = ^{bus.bus_wdata[31:16], bus.bus_addr[1:0]};

   function automatic logic hit(input logic [ADDR_W-3:0] idx, input int k);
      return idx == (ADDR_W-2)'(k);
   endfunction

   always_comb begin
      state_d  = state_q;
      cr_d     = cr_q;
      psc_d    = psc_q;
      arr_d    = arr_q;
      ccr1_d   = ccr1_q;
      ccr2_d   = ccr2_q;
      psc_a_d  = psc_a_q;
      arr_a_d  = arr_a_q;
      ccr1_a_d = ccr1_a_q;
      ccr2_a_d = ccr2_a_q;
      rdata_d  = 32'd0;
      load_all = 1'b0;
      ug       = wr && hit(widx, 7) && bus.bus_wdata[0];

      if (wr && hit(widx, 0)) cr_d   = bus.bus_wdata[4:0];
      if (wr && hit(widx, 2)) psc_d  = wd;
      if (wr && hit(widx, 3)) arr_d  = wd;
      if (wr && hit(widx, 4)) ccr1_d = wd;
      if (wr && hit(widx, 5)) ccr2_d = wd;

      // Set wins over a same-cycle W1C clear.
      uif_d = upd | (uif_q & ~(wr && hit(widx, 1) && bus.bus_wdata[0]));

      // Preload writes bypass straight to active unless buffered (RUN+ARPE).
      imm = (state_q != RUN) || !cr_q[ARPE];

      unique case (state_q)
         IDLE: begin
            if (ug) load_all = 1'b1;
            if (wr && hit(widx, 0) && bus.bus_wdata[EN]) state_d = RUN;
         end
         RUN: begin
            if (wr && hit(widx, 0) && !bus.bus_wdata[EN]) begin
               state_d = IDLE;                   // no reload even if upd
            end else if (ug) begin
               state_d  = RESTART;
               load_all = 1'b1;
            end else if (upd) begin
               if (cr_q[ARPE]) load_all = 1'b1;
               // A same-cycle CR write overrides the one-pulse stop.
               if (cr_q[OPM] && !(wr && hit(widx, 0))) begin
                  cr_d[EN] = 1'b0;
                  state_d  = IDLE;
               end
            end
         end
         RESTART: begin
            if (wr && hit(widx, 0) && !bus.bus_wdata[EN]) state_d = IDLE;
            else                                          state_d = RUN;
         end
         default: state_d = IDLE;
      endcase

      // Reload uses the *_d preload so a same-cycle write is taken.
      if (load_all) begin
         psc_a_d  = psc_d;
         arr_a_d  = arr_d;
         ccr1_a_d = ccr1_d;
         ccr2_a_d = ccr2_d;
      end else if (imm) begin
         psc_a_d  = psc_d;
         arr_a_d  = arr_d;
         ccr1_a_d = ccr1_d;
         ccr2_a_d = ccr2_d;
      end

      tim_en_d = (state_d == RUN);
      irq_d    = uif_q & cr_q[UIE];

      if (rd) begin
         unique case (widx)
            (ADDR_W-2)'(0): rdata_d = {27'd0, cr_q};
            (ADDR_W-2)'(1): rdata_d = {31'd0, uif_q};
            (ADDR_W-2)'(2): rdata_d = {16'd0, psc_q};
            (ADDR_W-2)'(3): rdata_d = {16'd0, arr_q};
            (ADDR_W-2)'(4): rdata_d = {16'd0, ccr1_q};
            (ADDR_W-2)'(5): rdata_d = {16'd0, ccr2_q};
            (ADDR_W-2)'(6): rdata_d = {16'd0, tim_cnt};
            default:        rdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cr_q     <= '0;
         uif_q    <= 1'b0;
         psc_q    <= PSC_RST;
         arr_q    <= ARR_RST;
         ccr1_q   <= '0;
         ccr2_q   <= '0;
         psc_a_q  <= PSC_RST;
         arr_a_q  <= ARR_RST;
         ccr1_a_q <= '0;
         ccr2_a_q <= '0;
         tim_en_q <= 1'b0;
         ev_q     <= 1'b0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cr_q     <= cr_d;
         uif_q    <= uif_d;
         psc_q    <= psc_d;
         arr_q    <= arr_d;
         ccr1_q   <= ccr1_d;
         ccr2_q   <= ccr2_d;
         psc_a_q  <= psc_a_d;
         arr_a_q  <= arr_a_d;
         ccr1_a_q <= ccr1_a_d;
         ccr2_a_q <= ccr2_a_d;
         tim_en_q <= tim_en_d;
         ev_q     <= tim_event;
         irq_q    <= irq_d;
         rdata_q  <= rdata_d;
         ready_q  <= bus.bus_sel;
      end
   end

   assign tim_en        = tim_en_q;
   assign tim_countdown = cr_q[DIR];
   assign tim_psc       = psc_a_q;
   assign tim_arr       = arr_a_q;
   assign tim_ccr1      = ccr1_a_q;
   assign tim_ccr2      = ccr2_a_q;
   assign irq           = irq_q;
   assign bus.bus_rdata = rdata_q;
   assign bus.bus_ready = ready_q;

endmodule
